// File: rtl/stm_frm_pkg.sv
// Shared STM-1 frame geometry, sequencer state encoding and row indices
// used by the TX frame sequencer slice.
package stm_frm_pkg;

    localparam int STM1_NROW = 9;
    localparam int STM1_NCOL = 90;
    localparam int STM1_NSUB = 3;
    localparam int STM1_NTOH = 3;

    localparam logic [3:0] ROW_PTR   = 4'd3;
    localparam logic [3:0] ROW_MSOH0 = 4'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } frm_state_t;

endpackage

// File: rtl/frmseq_modcnt.sv
// Modulo-N position counter with clear-to-zero, count enable and carry-out
// on the N-1 -> 0 wrap; the next value is exported for registered decodes.
module frmseq_modcnt #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic         clk19,
    input  logic         rst19,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         co
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         at_max_s;

    assign at_max_s = (cnt_r == W'(N - 1));
    assign co       = inc & ~clr & at_max_s;
    assign cnt      = cnt_r;
    assign cnt_nxt  = cnt_nxt_s;

    // next-count selection: clear dominates, then wrap or increment
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (inc) begin
            cnt_nxt_s = at_max_s ? '0 : (cnt_r + W'(1));
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // count register
    always_ff @(posedge clk19) begin
        if (rst19) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/tx_stm_frmseq.sv
// STM-1 transmit frame sequencer: row/col/sub byte position, TOH window strobes,
// multiframe count and fsync alignment with loss hysteresis, all registered.
module tx_stm_frmseq
    import stm_frm_pkg::*;
#(
    parameter int NROW      = STM1_NROW,
    parameter int NCOL      = STM1_NCOL,
    parameter int NSUB      = STM1_NSUB,
    parameter int NTOH      = STM1_NTOH,
    parameter int SYNC_LOSS = 3,
    parameter int FREERUN   = 1
) (
    input  logic       clk19,
    input  logic       rst19,
    input  logic       en,
    input  logic       fsync,
    output logic [3:0] ps_rrow,
    output logic [6:0] ps_rcol,
    output logic [1:0] ps_rsub,
    output logic       frm_start,
    output logic       soh_win,
    output logic       ptr_win,
    output logic       msoh_win,
    output logic [1:0] mfrm,
    output logic       running,
    output logic       realign
);

    localparam int MW = $clog2(SYNC_LOSS + 1);

    frm_state_t  state_r;
    logic [MW-1:0] mis_cnt_r;

    logic [3:0] row_s, row_nxt_s;
    logic [6:0] col_s, col_nxt_s;
    logic [1:0] sub_s, sub_nxt_s;
    logic       sub_co_s, col_co_s, wrap_s;

    logic at_last_s, mis_hit_s, resync_s, align_s;
    logic run_nxt_s, advance_s, nxt_zero_s, toh_s;

    assign at_last_s  = (row_s == 4'(NROW - 1)) & (col_s == 7'(NCOL - 1)) & (sub_s == 2'(NSUB - 1));
    assign mis_hit_s  = (state_r == RUN) & fsync & ~at_last_s;
    assign resync_s   = en & mis_hit_s & (mis_cnt_r == MW'(SYNC_LOSS - 1));
    assign align_s    = en & (state_r == ALIGN) & fsync;
    // a realign load replaces the normal advance and forces the counters to zero
    assign advance_s  = en & (state_r == RUN) & ~resync_s;
    assign nxt_zero_s = (row_nxt_s == 4'd0) & (col_nxt_s == 7'd0) & (sub_nxt_s == 2'd0);
    assign toh_s      = (col_nxt_s < 7'(NTOH));

    // whether the sequencer is in RUN on the next cycle
    always_comb begin
        run_nxt_s = 1'b0;
        case (state_r)
            IDLE:    run_nxt_s = en & (FREERUN != 0);
            ALIGN:   run_nxt_s = en & fsync;
            RUN:     run_nxt_s = en;
            default: run_nxt_s = 1'b0;
        endcase
    end

    frmseq_modcnt #(.N(NSUB), .W(2)) u_sub (
        .clk19(clk19), .rst19(rst19), .clr(~advance_s), .inc(advance_s),
        .cnt(sub_s), .cnt_nxt(sub_nxt_s), .co(sub_co_s)
    );

    frmseq_modcnt #(.N(NCOL), .W(7)) u_col (
        .clk19(clk19), .rst19(rst19), .clr(~advance_s), .inc(sub_co_s),
        .cnt(col_s), .cnt_nxt(col_nxt_s), .co(col_co_s)
    );

    frmseq_modcnt #(.N(NROW), .W(4)) u_row (
        .clk19(clk19), .rst19(rst19), .clr(~advance_s), .inc(col_co_s),
        .cnt(row_s), .cnt_nxt(row_nxt_s), .co(wrap_s)
    );

    assign ps_rrow = row_s;
    assign ps_rcol = col_s;
    assign ps_rsub = sub_s;

    // FSM, mismatch hysteresis, multiframe count and registered window decode
    always_ff @(posedge clk19) begin
        if (rst19) begin
            state_r   <= IDLE;
            mis_cnt_r <= '0;
            frm_start <= 1'b0;
            soh_win   <= 1'b0;
            ptr_win   <= 1'b0;
            msoh_win  <= 1'b0;
            mfrm      <= 2'd0;
            running   <= 1'b0;
            realign   <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    state_r <= !en ? IDLE : ((FREERUN != 0) ? RUN : ALIGN);
                ALIGN:   state_r <= !en ? IDLE : (fsync ? RUN : ALIGN);
                RUN:     state_r <= en ? RUN : IDLE;
                default: state_r <= IDLE;
            endcase

            if (!en || state_r != RUN) begin
                mis_cnt_r <= '0;
            end else if (fsync) begin
                if (at_last_s || resync_s) begin
                    mis_cnt_r <= '0;
                end else if (mis_cnt_r != MW'(SYNC_LOSS)) begin
                    mis_cnt_r <= mis_cnt_r + MW'(1);
                end else begin
                    mis_cnt_r <= mis_cnt_r;
                end
            end else begin
                mis_cnt_r <= mis_cnt_r;
            end

            // entering RUN or reloading by fsync restarts the multiframe count
            if (!run_nxt_s || state_r != RUN || resync_s) begin
                mfrm <= 2'd0;
            end else if (wrap_s) begin
                mfrm <= mfrm + 2'd1;
            end else begin
                mfrm <= mfrm;
            end

            running   <= run_nxt_s;
            realign   <= align_s | resync_s;
            frm_start <= run_nxt_s & nxt_zero_s;
            soh_win   <= run_nxt_s & toh_s & (row_nxt_s < ROW_PTR);
            ptr_win   <= run_nxt_s & toh_s & (row_nxt_s == ROW_PTR);
            msoh_win  <= run_nxt_s & toh_s & (row_nxt_s >= ROW_MSOH0) & (row_nxt_s < 4'(NROW));
        end
    end

endmodule

// File: tb/tb_tx_stm_frmseq.sv
// Directed bench for the STM-1 TX frame sequencer: free-running and
// fsync-aligned instances share one clock and reset.
module tb_tx_stm_frmseq;

    logic clk19 = 1'b0;
    logic rst19 = 1'b1;
    logic en_fr = 1'b0, fsync_fr = 1'b0;
    logic en_al = 1'b0, fsync_al = 1'b0;

    logic [3:0] f_rrow, a_rrow;
    logic [6:0] f_rcol, a_rcol;
    logic [1:0] f_rsub, a_rsub;
    logic       f_frm, f_soh, f_ptr, f_msoh, f_run, f_realign;
    logic       a_frm, a_soh, a_ptr, a_msoh, a_run, a_realign;
    logic [1:0] f_mfrm, a_mfrm;

    int n_chk  = 0;
    int n_fail = 0;
    int fi     = 0;
    int soh_n  = 0, ptr_n = 0, msoh_n = 0, frm_n = 0;

    always #5 clk19 = ~clk19;

    tx_stm_frmseq #(.FREERUN(1)) dut_fr (
        .clk19(clk19), .rst19(rst19), .en(en_fr), .fsync(fsync_fr),
        .ps_rrow(f_rrow), .ps_rcol(f_rcol), .ps_rsub(f_rsub),
        .frm_start(f_frm), .soh_win(f_soh), .ptr_win(f_ptr), .msoh_win(f_msoh),
        .mfrm(f_mfrm), .running(f_run), .realign(f_realign)
    );

    tx_stm_frmseq #(.FREERUN(0)) dut_al (
        .clk19(clk19), .rst19(rst19), .en(en_al), .fsync(fsync_al),
        .ps_rrow(a_rrow), .ps_rcol(a_rcol), .ps_rsub(a_rsub),
        .frm_start(a_frm), .soh_win(a_soh), .ptr_win(a_ptr), .msoh_win(a_msoh),
        .mfrm(a_mfrm), .running(a_run), .realign(a_realign)
    );

    wire [12:0] fr_pos = {f_rrow, f_rcol, f_rsub};
    wire [12:0] al_pos = {a_rrow, a_rcol, a_rsub};
    wire [20:0] fr_all = {fr_pos, f_frm, f_soh, f_ptr, f_msoh, f_mfrm, f_run, f_realign};
    wire [20:0] al_all = {al_pos, a_frm, a_soh, a_ptr, a_msoh, a_mfrm, a_run, a_realign};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] exp_pos(input int i);
        return {4'(i / 270), 7'((i % 270) / 3), 2'(i % 3)};
    endfunction

    task automatic step();
        @(posedge clk19);
        #1;
    endtask

    task automatic step_fr();
        step();
        fi = (fi + 1) % 2430;
    endtask

    task automatic adv_to(input int t);
        while (fi != t) step_fr();
    endtask

    task automatic pulse_fr();
        fsync_fr = 1'b1;
        step_fr();
        fsync_fr = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_fr_all", 32'(fr_all), 32'd0);
        chk("rst_al_all", 32'(al_all), 32'd0);
        rst19 = 1'b0;
        step();
        chk("idle_fr_all", 32'(fr_all), 32'd0);

        // 1/2: free-run start, one full frame walked position by position
        en_fr = 1'b1;
        step();
        fi = 0;
        for (int i = 0; i < 2430; i++) begin
            chk("t1_pos", 32'(fr_pos), 32'(exp_pos(i)));
            soh_n  += int'(f_soh);
            ptr_n  += int'(f_ptr);
            msoh_n += int'(f_msoh);
            frm_n  += int'(f_frm);
            if (i == 0) begin
                chk("t1_frm0", 32'(f_frm), 32'd1);
                chk("t1_run0", 32'(f_run), 32'd1);
                chk("t1_mfrm0", 32'(f_mfrm), 32'd0);
            end
            if (i == 269) chk("t2_col89", 32'(f_rcol), 32'd89);
            if (i == 270) chk("t2_row1", 32'(f_rrow), 32'd1);
            if (i == 809) chk("t2_ptr809", 32'(f_ptr), 32'd0);
            if (i == 810) chk("t2_ptr810", 32'(f_ptr), 32'd1);
            if (i == 818) chk("t2_ptr818", 32'(f_ptr), 32'd1);
            if (i == 819) chk("t2_ptr819", 32'(f_ptr), 32'd0);
            if (i == 1080) chk("t2_msoh1080", 32'(f_msoh), 32'd1);
            step_fr();
        end
        chk("t1_soh_n", 32'(soh_n), 32'd27);
        chk("t1_ptr_n", 32'(ptr_n), 32'd9);
        chk("t1_msoh_n", 32'(msoh_n), 32'd45);
        chk("t1_frm_n", 32'(frm_n), 32'd1);
        chk("t1_wrap_pos", 32'(fr_pos), 32'd0);
        chk("t1_wrap_frm", 32'(f_frm), 32'd1);
        chk("t1_wrap_mfrm", 32'(f_mfrm), 32'd1);

        // 4: two early pulses, one aligned, then three misplaced
        adv_to(2424);
        pulse_fr();
        chk("t4_early1_ra", 32'(f_realign), 32'd0);
        chk("t4_early1_pos", 32'(fr_pos), 32'(exp_pos(2425)));
        adv_to(0);
        chk("t4_mfrm2", 32'(f_mfrm), 32'd2);
        adv_to(2424);
        pulse_fr();
        chk("t4_early2_ra", 32'(f_realign), 32'd0);
        adv_to(2429);
        pulse_fr();
        chk("t4_align_ra", 32'(f_realign), 32'd0);
        chk("t4_align_frm", 32'(f_frm), 32'd1);
        chk("t4_mfrm3", 32'(f_mfrm), 32'd3);
        adv_to(100);
        pulse_fr();
        chk("t4_mis1_ra", 32'(f_realign), 32'd0);
        adv_to(200);
        pulse_fr();
        chk("t4_mis2_ra", 32'(f_realign), 32'd0);
        adv_to(300);
        pulse_fr();
        fi = 0;
        chk("t4_mis3_ra", 32'(f_realign), 32'd1);
        chk("t4_mis3_pos", 32'(fr_pos), 32'd0);
        chk("t4_mis3_mfrm", 32'(f_mfrm), 32'd0);
        chk("t4_mis3_frm", 32'(f_frm), 32'd1);
        step_fr();
        chk("t4_after_ra", 32'(f_realign), 32'd0);
        chk("t4_after_pos", 32'(fr_pos), 32'(exp_pos(1)));

        // 5: drop enable at row 4 col 17, then re-enable
        adv_to(1131);
        chk("t5_pos", 32'(fr_pos), 32'({4'd4, 7'd17, 2'd0}));
        en_fr = 1'b0;
        step();
        chk("t5_off_all", 32'(fr_all), 32'd0);
        en_fr = 1'b1;
        step();
        fi = 0;
        chk("t5_re_pos", 32'(fr_pos), 32'd0);
        chk("t5_re_frm", 32'(f_frm), 32'd1);
        chk("t5_re_run", 32'(f_run), 32'd1);

        // 3: aligned instance waits for fsync at cycle 100
        en_al = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            step_fr();
            chk("t3_wait_run", 32'(a_run), 32'd0);
        end
        fsync_al = 1'b1;
        step_fr();
        fsync_al = 1'b0;
        chk("t3_ra", 32'(a_realign), 32'd1);
        chk("t3_pos", 32'(al_pos), 32'd0);
        chk("t3_frm", 32'(a_frm), 32'd1);
        chk("t3_run", 32'(a_run), 32'd1);
        step_fr();
        chk("t3_ra_off", 32'(a_realign), 32'd0);
        chk("t3_pos1", 32'(al_pos), 32'(exp_pos(1)));
        // fsync coincident with enable drop: enable drop wins
        en_al = 1'b0;
        fsync_al = 1'b1;
        step_fr();
        fsync_al = 1'b0;
        chk("t3_off_all", 32'(al_all), 32'd0);

        // 6: reset mid-frame with coincident fsync
        adv_to(500);
        rst19 = 1'b1;
        fsync_fr = 1'b1;
        step();
        chk("t6_rst_all", 32'(fr_all), 32'd0);
        rst19 = 1'b0;
        fsync_fr = 1'b0;
        step();
        chk("t6_restart_pos", 32'(fr_pos), 32'd0);
        chk("t6_restart_run", 32'(f_run), 32'd1);
        chk("t6_restart_ra", 32'(f_realign), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
